perf_monitor: RTL and testbench

Synthesizable, parametrised run-time performance monitor for the pipelined core. It watches `o_pc_debug`, `o_insn_vld` and a selectable output bus (typically `o_io_ledr`) and counts run cycles, valid instructions and reset-vector cycles from program start until the first change of the watched bus. It can also stop on a programmable timeout. Counters freeze on completion for readout by the bench or an on-chip debug path, and it is instantiated beside `pipeline` at SoC top level.

---
 rtl/perf_monitor.sv | 151 +++++++++++++++
 tb/tb_perf_monitor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// Purpose : run-time performance monitor; counts run cycles, retired insns and reset-vector cycles until the watched bus changes or a timeout hits.
// Latency : all outputs registered; an event sampled at edge N is visible just after edge N.
// Backpress: none; a passive observer that never stalls the core.
//
// Ports:
//   i_clk, i_rst (async, active-high), i_clr (sync clear and re-arm)
//   i_pc_debug, i_insn_vld, i_watch : observed core signals
//   o_state (0 IDLE, 1 RUN, 2 DONE), o_cycle_cnt, o_insn_cnt, o_zpc_cnt, o_watch_val
//   o_done (level), o_done_pulse (first DONE cycle), o_timeout, o_ovf (sticky saturation)
module perf_monitor #(
   parameter int unsigned       CNT_W    = 32,
   parameter int unsigned       PC_W     = 32,
   parameter int unsigned       WATCH_W  = 32,
   parameter logic [PC_W-1:0]   START_PC = '0,
   parameter logic [CNT_W-1:0]  TIMEOUT  = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clr,
   input  logic [PC_W-1:0]    i_pc_debug,
   input  logic               i_insn_vld,
   input  logic [WATCH_W-1:0] i_watch,
   output logic [1:0]         o_state,
   output logic [CNT_W-1:0]   o_cycle_cnt,
   output logic [CNT_W-1:0]   o_insn_cnt,
   output logic [CNT_W-1:0]   o_zpc_cnt,
   output logic [WATCH_W-1:0] o_watch_val,
   output logic               o_done,
   output logic               o_done_pulse,
   output logic               o_timeout,
   output logic               o_ovf
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cycle_q, cycle_d;
   logic [CNT_W-1:0]     insn_q, insn_d;
   logic [CNT_W-1:0]     zpc_q, zpc_d;
   logic [WATCH_W-1:0]   watch_q;
   logic [WATCH_W-1:0]   wval_q, wval_d;
   logic                 done_q, done_d;
   logic                 pulse_q, pulse_d;
   logic                 to_q, to_d;
   logic                 ovf_q, ovf_d;

   logic                 watch_chg;
   logic                 pc_at_start;
   logic                 counting;
   logic                 cyc_sat, insn_sat, zpc_sat;
   logic [CNT_W-1:0]     cyc_inc;
   logic                 to_hit;

   always_comb begin
      state_d   = state_q;
      cycle_d   = cycle_q;
      insn_d    = insn_q;
      zpc_d     = zpc_q;
      wval_d    = wval_q;
      to_d      = to_q;
      ovf_d     = ovf_q;
      pulse_d   = 1'b0;

      watch_chg   = (i_watch != watch_q);
      pc_at_start = (i_pc_debug == START_PC);
      // The arming cycle itself is counted as run cycle 1.
      counting    = (state_q == ST_RUN) || ((state_q == ST_IDLE) && !pc_at_start);

      cyc_sat  = (cycle_q == CNT_MAX);
      insn_sat = (insn_q == CNT_MAX);
      zpc_sat  = (zpc_q == CNT_MAX);
      cyc_inc  = cyc_sat ? cycle_q : (cycle_q + CNT_ONE);
      // Compared against the saturated count, so a TIMEOUT of CNT_MAX still fires.
      to_hit   = (TIMEOUT != '0) && (cyc_inc == TIMEOUT);

      if (i_clr) begin
         state_d = ST_IDLE;
         cycle_d = '0;
         insn_d  = '0;
         zpc_d   = '0;
         wval_d  = '0;
         to_d    = 1'b0;
         ovf_d   = 1'b0;
      end else if (counting) begin
         cycle_d = cyc_inc;
         if (i_insn_vld && !insn_sat) begin
            insn_d = insn_q + CNT_ONE;
         end
         if (pc_at_start && !zpc_sat) begin
            zpc_d = zpc_q + CNT_ONE;
         end
         // Overflow flags an increment that was dropped because the counter was already full.
         ovf_d = ovf_q | cyc_sat | (i_insn_vld & insn_sat) | (pc_at_start & zpc_sat);

         if (watch_chg || to_hit) begin
            state_d = ST_DONE;
            wval_d  = i_watch;
            to_d    = !watch_chg;   // watch change wins over a simultaneous timeout
            pulse_d = 1'b1;
         end else begin
            state_d = ST_RUN;
         end
      end

      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cycle_q <= '0;
         insn_q  <= '0;
         zpc_q   <= '0;
         watch_q <= '0;
         wval_q  <= '0;
         done_q  <= 1'b0;
         pulse_q <= 1'b0;
         to_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         insn_q  <= insn_d;
         zpc_q   <= zpc_d;
         watch_q <= i_watch;
         wval_q  <= wval_d;
         done_q  <= done_d;
         pulse_q <= pulse_d;
         to_q    <= to_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_state      = state_q;
   assign o_cycle_cnt  = cycle_q;
   assign o_insn_cnt   = insn_q;
   assign o_zpc_cnt    = zpc_q;
   assign o_watch_val  = wval_q;
   assign o_done       = done_q;
   assign o_done_pulse = pulse_q;
   assign o_timeout    = to_q;
   assign o_ovf        = ovf_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Purpose : three monitors (plain, TIMEOUT=16, CNT_W=4) share one stimulus and are compared to a behavioural model.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpress: none.
module tb_perf_monitor;
   localparam int N = 3;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_clr;
   logic [31:0] i_pc_debug;
   logic        i_insn_vld;
   logic [31:0] i_watch;

   logic [1:0]  st0, st1, st2;
   logic [31:0] cyc0, insn0, zpc0, cyc1, insn1, zpc1;
   logic [3:0]  cyc2, insn2, zpc2;
   logic [31:0] wv0, wv1, wv2;
   logic        dn0, dn1, dn2, pl0, pl1, pl2, to0, to1, to2, ov0, ov1, ov2;

   int checks = 0;
   int failures = 0;

   always #5 i_clk = ~i_clk;

   perf_monitor #(.CNT_W(32), .PC_W(32), .WATCH_W(32), .START_PC(32'd0), .TIMEOUT(32'd0)) dut0 (
      .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_clr), .i_pc_debug(i_pc_debug), .i_insn_vld(i_insn_vld),
      .i_watch(i_watch), .o_state(st0), .o_cycle_cnt(cyc0), .o_insn_cnt(insn0), .o_zpc_cnt(zpc0),
      .o_watch_val(wv0), .o_done(dn0), .o_done_pulse(pl0), .o_timeout(to0), .o_ovf(ov0));

   perf_monitor #(.CNT_W(32), .PC_W(32), .WATCH_W(32), .START_PC(32'd0), .TIMEOUT(32'd16)) dut1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_clr), .i_pc_debug(i_pc_debug), .i_insn_vld(i_insn_vld),
      .i_watch(i_watch), .o_state(st1), .o_cycle_cnt(cyc1), .o_insn_cnt(insn1), .o_zpc_cnt(zpc1),
      .o_watch_val(wv1), .o_done(dn1), .o_done_pulse(pl1), .o_timeout(to1), .o_ovf(ov1));

   perf_monitor #(.CNT_W(4), .PC_W(32), .WATCH_W(32), .START_PC(32'd0), .TIMEOUT(4'd0)) dut2 (
      .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_clr), .i_pc_debug(i_pc_debug), .i_insn_vld(i_insn_vld),
      .i_watch(i_watch), .o_state(st2), .o_cycle_cnt(cyc2), .o_insn_cnt(insn2), .o_zpc_cnt(zpc2),
      .o_watch_val(wv2), .o_done(dn2), .o_done_pulse(pl2), .o_timeout(to2), .o_ovf(ov2));

   // Behavioural model: phase 0 idle, 1 running, 2 done; counts clamp at the instance maximum.
   int          m_state [N];
   longint      m_cyc   [N];
   longint      m_insn  [N];
   longint      m_zpc   [N];
   logic [31:0] m_wval  [N];
   bit          m_to    [N];
   bit          m_ovf   [N];
   bit          m_pulse [N];
   longint      m_max   [N] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
   longint      m_lim   [N] = '{64'd0, 64'd16, 64'd0};
   logic [31:0] m_wq;
   int          pulse_cnt [N];

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_state[k] = 0; m_cyc[k] = 0; m_insn[k] = 0; m_zpc[k] = 0;
         m_wval[k] = '0; m_to[k] = 0; m_ovf[k] = 0; m_pulse[k] = 0;
      end
      m_wq = '0;
   endtask

   task automatic model_edge();
      for (int k = 0; k < N; k++) begin
         if (i_clr) begin
            m_state[k] = 0; m_cyc[k] = 0; m_insn[k] = 0; m_zpc[k] = 0;
            m_wval[k] = '0; m_to[k] = 0; m_ovf[k] = 0; m_pulse[k] = 0;
         end else begin
            m_pulse[k] = 0;
            if (m_state[k] == 1 || (m_state[k] == 0 && i_pc_debug != 0)) begin
               if (m_cyc[k] == m_max[k]) m_ovf[k] = 1; else m_cyc[k]++;
               if (i_insn_vld) begin
                  if (m_insn[k] == m_max[k]) m_ovf[k] = 1; else m_insn[k]++;
               end
               if (i_pc_debug == 0) begin
                  if (m_zpc[k] == m_max[k]) m_ovf[k] = 1; else m_zpc[k]++;
               end
               if (i_watch != m_wq) begin
                  m_state[k] = 2; m_wval[k] = i_watch; m_to[k] = 0; m_pulse[k] = 1;
               end else if (m_lim[k] != 0 && m_cyc[k] == m_lim[k]) begin
                  m_state[k] = 2; m_wval[k] = i_watch; m_to[k] = 1; m_pulse[k] = 1;
               end else begin
                  m_state[k] = 1;
               end
            end
         end
      end
      m_wq = i_watch;
   endtask

   task automatic cmp(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check_inst(input int k, input logic [1:0] st, input logic [31:0] cyc, input logic [31:0] insn,
                             input logic [31:0] zpc, input logic [31:0] wv, input logic dn, input logic pl,
                             input logic to, input logic ov);
      cmp($sformatf("state%0d", k), st, m_state[k]);
      cmp($sformatf("cycle%0d", k), cyc, m_cyc[k]);
      cmp($sformatf("insn%0d", k), insn, m_insn[k]);
      cmp($sformatf("zpc%0d", k), zpc, m_zpc[k]);
      cmp($sformatf("watch_val%0d", k), wv, m_wval[k]);
      cmp($sformatf("done%0d", k), dn, (m_state[k] == 2) ? 1 : 0);
      cmp($sformatf("pulse%0d", k), pl, m_pulse[k]);
      cmp($sformatf("timeout%0d", k), to, m_to[k]);
      cmp($sformatf("ovf%0d", k), ov, m_ovf[k]);
   endtask

   task automatic check_all();
      check_inst(0, st0, cyc0, insn0, zpc0, wv0, dn0, pl0, to0, ov0);
      check_inst(1, st1, cyc1, insn1, zpc1, wv1, dn1, pl1, to1, ov1);
      check_inst(2, st2, 32'(cyc2), 32'(insn2), 32'(zpc2), wv2, dn2, pl2, to2, ov2);
   endtask

   task automatic step();
      model_edge();
      @(posedge i_clk);
      #1;
      pulse_cnt[0] += int'(pl0);
      pulse_cnt[1] += int'(pl1);
      pulse_cnt[2] += int'(pl2);
      check_all();
   endtask

   // Called just after a sampling point; reset lands mid-cycle, away from any edge.
   task automatic async_reset();
      #2;
      i_rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge i_clk);
      #1;
      check_all();
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic run_prog(input int n_idle, input int n_run, input int chg_at, input logic [31:0] old_w,
                           input logic [31:0] new_w, input bit bubbles, input int z_from, input int z_len);
      i_clr = 1'b1; i_pc_debug = '0; i_insn_vld = 1'b1; i_watch = old_w;
      step();
      i_clr = 1'b0;
      for (int k = 0; k < N; k++) pulse_cnt[k] = 0;
      for (int i = 0; i < n_idle; i++) begin
         i_pc_debug = '0; i_watch = old_w;
         step();
      end
      for (int j = 1; j <= n_run; j++) begin
         i_pc_debug = (j >= z_from && j < z_from + z_len) ? 32'd0 : 32'(4 * j);
         i_insn_vld = bubbles ? ((j % 2) == 1) : 1'b1;
         i_watch    = (j >= chg_at) ? new_w : old_w;
         step();
      end
   endtask

   task automatic wander(input int n);
      for (int i = 0; i < n; i++) begin
         i_pc_debug = $urandom;
         i_insn_vld = 1'($urandom);
         i_watch    = $urandom;
         step();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b1; i_clr = 1'b0; i_pc_debug = '0; i_insn_vld = 1'b0; i_watch = '0;
      model_reset();
      for (int k = 0; k < N; k++) pulse_cnt[k] = 0;
      #12;
      check_all();
      cmp("reset_state_lit", st0, 0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // Basic run: 5 idle cycles, watch 0 -> 5050 on run cycle 20.
      run_prog(5, 20, 20, 32'd0, 32'd5050, 1'b0, 0, 0);
      wander(10);
      cmp("basic_cycle_lit", cyc0, 20);
      cmp("basic_insn_lit", insn0, 20);
      cmp("basic_zpc_lit", zpc0, 0);
      cmp("basic_wval_lit", wv0, 5050);
      cmp("basic_pulses_lit", pulse_cnt[0], 1);
      cmp("basic_state_lit", st0, 2);
      cmp("timeout16_cycle_lit", cyc1, 16);
      cmp("timeout16_flag_lit", to1, 1);
      cmp("sat_cycle_lit", cyc2, 15);
      cmp("sat_ovf_lit", ov2, 1);
      cmp("sat_state_lit", st2, 2);

      // Bubbles plus three mid-run cycles at the reset vector; change on run cycle 30.
      run_prog(2, 30, 30, 32'd7, 32'd9, 1'b1, 10, 3);
      cmp("bubble_cycle_lit", cyc0, 30);
      cmp("bubble_insn_lit", insn0, 15);
      cmp("bubble_zpc_lit", zpc0, 3);

      // Watch change coincident with timeout: watch wins.
      run_prog(1, 16, 16, 32'd9, 32'd11, 1'b0, 0, 0);
      cmp("tie_cycle_lit", cyc1, 16);
      cmp("tie_timeout_lit", to1, 0);
      cmp("tie_state_lit", st1, 2);

      // Clear in the same cycle as a terminating watch change.
      run_prog(1, 8, 99, 32'd11, 32'd11, 1'b0, 0, 0);
      i_clr = 1'b1; i_pc_debug = 32'd36; i_watch = 32'd77;
      step();
      cmp("clr_state_lit", st0, 0);
      cmp("clr_cycle_lit", cyc0, 0);
      cmp("clr_pulse_lit", pl0, 0);
      i_clr = 1'b0; i_pc_debug = 32'd40;
      step();
      cmp("rearm_state_lit", st0, 1);
      cmp("rearm_cycle_lit", cyc0, 1);

      // Asynchronous reset in the middle of a run.
      run_prog(0, 7, 99, 32'd3, 32'd3, 1'b0, 0, 0);
      cmp("prereset_cycle_lit", cyc0, 7);
      async_reset();
      cmp("reset_cycle_lit", cyc0, 0);
      cmp("reset_state2_lit", st0, 0);

      // Randomized traffic.
      i_watch = '0;
      for (int i = 0; i < 3000; i++) begin
         i_clr      = ($urandom_range(49) == 0);
         i_pc_debug = ($urandom_range(5) == 0) ? 32'd0 : $urandom;
         i_insn_vld = 1'($urandom);
         if ($urandom_range(24) == 0) i_watch = $urandom;
         step();
         if ($urandom_range(499) == 0) begin
            i_clr = 1'b0;
            async_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
